// File: rtl/ahb_lite_master_if.sv
// Single-outstanding AHB-Lite initiator: turns one core load/store request into
// an AHB-Lite address phase plus data phase and returns one ack pulse per request.
module ahb_lite_master_if #(
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic [1:0]  HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_wdata;
  logic [31:0] w_hwdataRep;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_reject;
  logic        w_issue;
  logic        w_addrDone;
  logic        w_dataDone;
  logic        w_respDone;
  logic        w_unused;

  assign HBURST   = 3'b000;
  assign HPROT    = HPROT_VAL;
  assign w_unused = HRESP[1];

  always_comb begin
    w_misaligned = 1'b0;
    case (size_i)
      3'b000:  w_misaligned = 1'b0;
      3'b001:  w_misaligned = addr_i[0];
      3'b010:  w_misaligned = |addr_i[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // HSIZE already holds the accepted size, so it selects the lane replication.
  always_comb begin
    w_hwdataRep = r_wdata;
    case (HSIZE)
      3'b000:  w_hwdataRep = {4{r_wdata[7:0]}};
      3'b001:  w_hwdataRep = {2{r_wdata[15:0]}};
      default: w_hwdataRep = r_wdata;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: if (req_i) w_stateNext = (ALIGN_CHECK && w_misaligned) ? S_RESP : S_ADDR;
      S_ADDR: if (HREADY) w_stateNext = S_DATA;
      S_DATA: if (HREADY) w_stateNext = S_RESP;
      S_RESP: w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept   = (r_state == S_IDLE) && req_i;
    w_reject   = w_accept && ALIGN_CHECK && w_misaligned;
    w_issue    = w_accept && !w_reject;
    w_addrDone = (r_state == S_ADDR) && HREADY;
    w_dataDone = (r_state == S_DATA) && HREADY;
    w_respDone = (r_state == S_RESP);
  end

  // A rejected request never touches the bus; it goes straight to the ack.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      busy_o  <= 1'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'h0;
      HADDR   <= 32'h0;
      HTRANS  <= 2'b00;
      HWRITE  <= 1'b0;
      HSIZE   <= 3'b010;
      HWDATA  <= 32'h0;
      r_wdata <= 32'h0;
    end else begin
      if (w_accept) begin
        busy_o  <= 1'b1;
        r_wdata <= wdata_i;
      end
      if (w_issue) begin
        HTRANS <= 2'b10;
        HADDR  <= addr_i;
        HWRITE <= we_i;
        HSIZE  <= size_i;
      end
      if (w_addrDone) begin
        HTRANS <= 2'b00;
        HWDATA <= w_hwdataRep;
      end
      if (w_dataDone) begin
        ack_o <= 1'b1;
        err_o <= HRESP[0];
        if (!HWRITE) rdata_o <= HRDATA;
      end
      if (w_reject) begin
        ack_o <= 1'b1;
        err_o <= 1'b1;
      end
      if (w_respDone) begin
        ack_o  <= 1'b0;
        err_o  <= 1'b0;
        busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Self-checking bench for ahb_lite_master_if: the bench plays the AHB slave
// cycle by cycle and scores each ack against a queue of expected responses.
module tb_ahb_lite_master_if;

  logic        HCLK;
  logic        HRESETn;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [2:0]  size_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        ack_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mRdata;
  int          total;
  int          bad;

  ahb_lite_master_if dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .size_i(size_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  // Drives one request in the current cycle and plays the slave for it.
  task automatic runXfer(input logic we, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input int addrWaits, input int dataWaits,
                         input logic slvErr, input logic [31:0] rdat,
                         input logic [31:0] expHwdata, input logic misal, input logic busyReq);
    exp_t e;
    e.err   = misal | slvErr;
    e.rdata = (!we && !misal) ? rdat : mRdata;
    mRdata  = e.rdata;
    sbq.push_back(e);
    req_i = 1'b1; we_i = we; addr_i = addr; size_i = size; wdata_i = wdata;
    HREADY = 1'b1; HRESP = 2'b00;
    tick;
    req_i = 1'b0; we_i = ~we; addr_i = $urandom; wdata_i = $urandom; size_i = 3'b111;
    if (!misal) begin
      for (int i = 0; i <= addrWaits; i++) begin
        total++;
        if ({HTRANS, HADDR, HWRITE, HSIZE, busy_o} !== {2'b10, addr, we, size, 1'b1}) begin
          bad++;
          $display("[TB] FAIL addr_phase: got %h/%h/%b/%b/%b want 2/%h/%b/%b/1",
                   HTRANS, HADDR, HWRITE, HSIZE, busy_o, addr, we, size);
        end
        HREADY = (i == addrWaits);
        tick;
      end
      for (int i = 0; i <= dataWaits; i++) begin
        total++;
        if ({HTRANS, HADDR, HWRITE, HSIZE, ack_o, busy_o} !== {2'b00, addr, we, size, 1'b0, 1'b1}) begin
          bad++;
          $display("[TB] FAIL data_phase: got %h/%h/%b/%b/ack%b/busy%b want 0/%h/%b/%b/ack0/busy1",
                   HTRANS, HADDR, HWRITE, HSIZE, ack_o, busy_o, addr, we, size);
        end
        if (we) begin
          total++;
          if (HWDATA !== expHwdata) begin
            bad++;
            $display("[TB] FAIL hwdata: got %h want %h", HWDATA, expHwdata);
          end
        end
        HREADY = (i == dataWaits);
        HRESP  = (slvErr && (i + 1 >= dataWaits)) ? 2'b01 : 2'b00;
        HRDATA = rdat;
        req_i  = busyReq && (i < dataWaits);
        tick;
      end
      req_i = 1'b0; HRESP = 2'b00; HREADY = 1'b1; HRDATA = $urandom;
    end
    total++;
    if ({ack_o, HTRANS} !== {1'b1, 2'b00}) begin
      bad++;
      $display("[TB] FAIL ack: got ack=%b htrans=%b want ack=1 htrans=00", ack_o, HTRANS);
    end
    if (ack_o === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("[TB] FAIL resp: got ack with empty queue want none");
      end else begin
        e = sbq.pop_front();
        if ({err_o, rdata_o} !== {e.err, e.rdata}) begin
          bad++;
          $display("[TB] FAIL resp: got err=%b rdata=%h want err=%b rdata=%h",
                   err_o, rdata_o, e.err, e.rdata);
        end
      end
    end
    tick;
    total++;
    if ({ack_o, busy_o, HTRANS} !== {1'b0, 1'b0, 2'b00}) begin
      bad++;
      $display("[TB] FAIL idle_after: got ack=%b busy=%b htrans=%b want 0/0/00", ack_o, busy_o, HTRANS);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA, ack_o, err_o, rdata_o, busy_o, HBURST, HPROT} !==
        {2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 4'b0011}) begin
      bad++;
      $display("[TB] FAIL reset: got %b/%h/%b/%b/%h/%b/%b/%h/%b/%b/%b want 00/0/0/010/0/0/0/0/0/000/0011",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA, ack_o, err_o, rdata_o, busy_o, HBURST, HPROT);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick;
  endtask

  task automatic test_word_store;
    runXfer(1'b1, 32'h100, 3'b010, 32'h12345678, 0, 0, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0);
  endtask

  task automatic test_narrow_store;
    runXfer(1'b1, 32'h103, 3'b000, 32'h000000AB, 0, 0, 1'b0, 32'h0, 32'hABABABAB, 1'b0, 1'b0);
    runXfer(1'b1, 32'h102, 3'b001, 32'h0000BEEF, 0, 0, 1'b0, 32'h0, 32'hBEEFBEEF, 1'b0, 1'b0);
    runXfer(1'b1, 32'h101, 3'b000, 32'h5A5A1234, 1, 0, 1'b0, 32'h0, 32'h34343434, 1'b0, 1'b0);
  endtask

  task automatic test_wait_load;
    runXfer(1'b0, 32'h200, 3'b010, 32'h0, 0, 2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    runXfer(1'b0, 32'h204, 3'b010, 32'h0, 2, 1, 1'b0, 32'h0BADBEEF, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_misaligned;
    runXfer(1'b0, 32'h202, 3'b010, 32'h0, 0, 0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    runXfer(1'b1, 32'h101, 3'b001, 32'hFFFF, 0, 0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    runXfer(1'b0, 32'h000, 3'b011, 32'h0, 0, 0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_slave_error;
    runXfer(1'b1, 32'h400, 3'b010, 32'h87654321, 0, 1, 1'b1, 32'h0, 32'h87654321, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    runXfer(1'b0, 32'h500, 3'b010, 32'h0, 0, 0, 1'b0, 32'h11112222, 32'h0, 1'b0, 1'b0);
    runXfer(1'b1, 32'h504, 3'b010, 32'h33334444, 0, 0, 1'b0, 32'h0, 32'h33334444, 1'b0, 1'b0);
    runXfer(1'b0, 32'h508, 3'b001, 32'h0, 0, 0, 1'b0, 32'h55556666, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midflight;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h300; size_i = 3'b010; HREADY = 1'b1;
    tick;
    req_i = 1'b0;
    tick;
    HREADY = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    total++;
    if ({HTRANS, busy_o, HADDR, ack_o} !== {2'b00, 1'b0, 32'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL async_reset: got htrans=%b busy=%b haddr=%h ack=%b want 00/0/0/0",
               HTRANS, busy_o, HADDR, ack_o);
    end
    tick;
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    mRdata  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++;
      if ({ack_o, busy_o, HTRANS} !== {1'b0, 1'b0, 2'b00}) begin
        bad++;
        $display("[TB] FAIL no_ack_after_reset: got ack=%b busy=%b htrans=%b want 0/0/00",
                 ack_o, busy_o, HTRANS);
      end
    end
    runXfer(1'b0, 32'h304, 3'b010, 32'h0, 0, 1, 1'b0, 32'h13579BDF, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0; bad = 0; mRdata = 32'h0;
    HRESETn = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; size_i = 3'b010;
    wdata_i = 32'h0; HREADY = 1'b1; HRDATA = 32'h0; HRESP = 2'b00;
    #12;
    test_reset;
    test_word_store;
    test_narrow_store;
    test_wait_load;
    test_misaligned;
    test_slave_error;
    test_back_to_back;
    test_reset_midflight;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
